// File: rtl/simon_input_cond_pkg.sv
// Shared Simon definitions: default timing parameters and the button FSM encoding.
package simon_input_cond_pkg;

    localparam int SIMON_DEBOUNCE_CYCLES = 16;
    localparam int SIMON_PULSE_CYCLES    = 4;
    localparam int SIMON_SYNC_STAGES     = 2;

    typedef enum logic [1:0] {
        BTN_IDLE  = 2'd0,
        BTN_PULSE = 2'd1,
        BTN_HOLD  = 2'd2
    } btn_state_e;

endpackage

// File: rtl/simon_debounce.sv
// One asynchronous input: flop synchronizer followed by a saturating-count debouncer.
module simon_debounce
    import simon_input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SIMON_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SIMON_DEBOUNCE_CYCLES
) (
    input  logic sysclk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   clean_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign clean  = clean_q;

    // The counter only ever reaches DEBOUNCE_CYCLES-1 before clearing, so it cannot wrap.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (synced == clean_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                clean_q <= synced;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/simon_input_cond.sv
// Simon input conditioning: debounced switches plus one fixed-width pclk strobe per
// button press, with pattern/level frozen while the strobe is high.
module simon_input_cond
    import simon_input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SIMON_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = SIMON_PULSE_CYCLES,
    parameter int SYNC_STAGES     = SIMON_SYNC_STAGES
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [3:0] sw_raw,
    input  logic       lvl_raw,
    output logic       pclk,
    output logic [3:0] pattern,
    output logic       level,
    output logic [7:0] press_count
);

    localparam int PCNT_W = $clog2(PULSE_CYCLES) + 1;

    logic [5:0] raw_vec;
    logic [5:0] deb_vec;
    logic       deb_btn;
    logic [3:0] deb_sw;
    logic       deb_lvl;

    assign raw_vec = {lvl_raw, sw_raw, btn_raw};
    assign deb_btn = deb_vec[0];
    assign deb_sw  = deb_vec[4:1];
    assign deb_lvl = deb_vec[5];

    for (genvar i = 0; i < 6; i++) begin : g_cond
        simon_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .sysclk(sysclk),
            .rst   (rst),
            .raw   (raw_vec[i]),
            .clean (deb_vec[i])
        );
    end

    btn_state_e        state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              pclk_d;
    logic              accept;
    logic              freeze;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        accept  = 1'b0;
        case (state_q)
            BTN_IDLE: begin
                if (deb_btn) begin
                    state_d = BTN_PULSE;
                    pcnt_d  = '0;
                    accept  = 1'b1;
                end
            end
            BTN_PULSE: begin
                if (pcnt_q == PCNT_W'(PULSE_CYCLES - 1)) begin
                    state_d = BTN_HOLD;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PCNT_W'(1);
                end
            end
            BTN_HOLD: begin
                if (!deb_btn) begin
                    state_d = BTN_IDLE;
                end
            end
            default: state_d = BTN_IDLE;
        endcase
        pclk_d = (state_d == BTN_PULSE);
        // Loading on the PULSE->HOLD edge makes a change debounced mid-pulse show on HOLD's first cycle.
        freeze = (state_q == BTN_PULSE) && (state_d == BTN_PULSE);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= BTN_IDLE;
            pcnt_q      <= '0;
            pclk        <= 1'b0;
            pattern     <= '0;
            level       <= 1'b0;
            press_count <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            pclk    <= pclk_d;
            if (accept) begin
                press_count <= press_count + 8'd1;
            end
            if (!freeze) begin
                pattern <= deb_sw;
                level   <= deb_lvl;
            end
        end
    end

endmodule
